audio_mixer_2ch: RTL and testbench

Two-channel digital tone synthesizer and mixer for the audio practice chain, running at 12.5 MHz.
- Each channel is a phase-accumulator oscillator with a selectable waveform and 8-bit volume.
- The two channels are summed into one 8-bit unsigned (offset-128) mono sample stream, suitable for 8-bit PCM/WAV capture or a PWM DAC.
- Downstream logic decimates the output at any rate (e.g. 48 kHz).

---
 rtl/audio_pkg.sv | 39 +++
 rtl/audio_channel_osc.sv | 92 +++++++++
 rtl/audio_mixer_2ch.sv | 78 +++++++
 tb/tb_audio_mixer_2ch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the two-channel tone mixer.
// Holds the waveform select encoding, default phase width, mid-scale
// output code and the quarter-wave sine table used by each oscillator.
package audio_pkg;

  localparam int         PHASE_W_DEF = 27;
  localparam logic [7:0] SAMPLE_MID  = 8'd128;

  typedef enum logic [2:0] {
    GEN_OFF    = 3'd0,
    GEN_SQUARE = 3'd1,
    GEN_SAW    = 3'd2,
    GEN_TRI    = 3'd3,
    GEN_SINE   = 3'd4,
    GEN_NOISE  = 3'd5
  } gen_sel_e;

  // round(127*sin(2*pi*i/256)) for i = 0..64; entry 64 is the positive peak
  localparam logic [6:0] SINE_QTR [65] = '{
      0,   3,   6,   9,  12,  16,  19,  22,  25,  28,
     31,  34,  37,  40,  43,  46,  49,  51,  54,  57,
     60,  63,  65,  68,  71,  73,  76,  78,  81,  83,
     85,  88,  90,  92,  94,  96,  98, 100, 102, 104,
    106, 107, 109, 111, 112, 113, 115, 116, 117, 118,
    120, 121, 122, 122, 123, 124, 125, 125, 126, 126,
    126, 127, 127, 127, 127
  };

  // Full-cycle sine from the quarter table: p[6] mirrors within a half,
  // p[7] selects the negative half.
  function automatic logic signed [7:0] sine_lut(input logic [7:0] p);
    logic [6:0] idx;
    logic [7:0] mag;
    idx = p[6] ? (7'd0 - p[6:0]) : p[6:0];
    mag = {1'b0, SINE_QTR[idx]};
    return p[7] ? -$signed(mag) : $signed(mag);
  endfunction

endpackage

// File: rtl/audio_channel_osc.sv
// One tone channel: phase accumulator, waveform shaping, volume scaling
// and the stage A sample register. Output is a signed 8-bit sample.
// Build option: AUDIO_NOISE_GEN_EN adds a per-channel 16-bit LFSR noise
// source on gen_sel 5; without it gen_sel 5 is silent and no LFSR exists.
module audio_channel_osc
  import audio_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF
`ifdef AUDIO_NOISE_GEN_EN
  ,
  parameter logic [15:0] NOISE_SEED = 16'hACE1
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [2:0]        gen_sel_i,
  input  logic [15:0]       freq_i,
  input  logic [7:0]        volume_i,
  output logic signed [7:0] sample_o
);

  logic [PHASE_W-1:0] phase_q, phase_d, phase_sum;
  logic [7:0]         p;
  logic [6:0]         tri_t;
  logic signed [7:0]  wave;
  logic signed [16:0] wave_x, vol_x;
  logic signed [15:0] prod;
  logic signed [7:0]  s_q, s_d;

  assign p = phase_q[PHASE_W-1 -: 8];

  // Next phase: wraps freely while enabled, parked at zero when disabled
  always_comb begin
    phase_sum = phase_q + PHASE_W'(freq_i);
    phase_d   = en_i ? phase_sum : '0;
  end

`ifdef AUDIO_NOISE_GEN_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR (taps 16,14,13,11) steps whenever the waveform index moves
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i && (phase_sum[PHASE_W-1 -: 8] != p)) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // LFSR register; keeps its state across disable so noise does not restart
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= NOISE_SEED;
    else       lfsr_q <= lfsr_d;
  end
`endif

  // Waveform shaping from the top 8 phase bits, then volume scaling (floor)
  always_comb begin
    tri_t = p[7] ? ~p[6:0] : p[6:0];
    wave  = '0;
    case (gen_sel_i)
      GEN_SQUARE: wave = p[7] ? -8'sd127 : 8'sd127;
      GEN_SAW:    wave = $signed(p ^ 8'h80);
      GEN_TRI:    wave = $signed({tri_t, 1'b0} - 8'd127);
      GEN_SINE:   wave = sine_lut(p);
`ifdef AUDIO_NOISE_GEN_EN
      GEN_NOISE:  wave = $signed(lfsr_q[7:0]);
`else
      GEN_NOISE:  wave = '0;
`endif
      default:    wave = '0;
    endcase
    wave_x = 17'(wave);
    vol_x  = $signed({9'd0, volume_i});
    prod   = 16'(wave_x * vol_x);
    s_d    = en_i ? 8'(prod >>> 8) : '0;
  end

  // Phase accumulator and stage A sample register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= '0;
      s_q     <= '0;
    end else begin
      phase_q <= phase_d;
      s_q     <= s_d;
    end
  end

  assign sample_o = s_q;

endmodule

// File: rtl/audio_mixer_2ch.sv
// Two-channel tone synthesizer and mixer. Two oscillator channels feed a
// stage B register that averages them into an offset-128 unsigned sample.
// Build option: AUDIO_NOISE_GEN_EN enables the LFSR noise waveform and the
// NOISE_SEED parameter.
module audio_mixer_2ch
  import audio_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF
`ifdef AUDIO_NOISE_GEN_EN
  ,
  parameter logic [15:0] NOISE_SEED = 16'hACE1
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ch0_en_i,
  input  logic [2:0]  ch0_gen_sel_i,
  input  logic [15:0] ch0_freq_i,
  input  logic [7:0]  ch0_volume_i,
  input  logic        ch1_en_i,
  input  logic [2:0]  ch1_gen_sel_i,
  input  logic [15:0] ch1_freq_i,
  input  logic [7:0]  ch1_volume_i,
  output logic [7:0]  sample_data_o
);

  logic signed [7:0] ch0_s, ch1_s;
  logic signed [8:0] sum_w;
  logic [7:0]        sample_q, sample_d;

  audio_channel_osc #(
    .PHASE_W    (PHASE_W)
`ifdef AUDIO_NOISE_GEN_EN
    ,
    .NOISE_SEED (NOISE_SEED)
`endif
  ) u_ch0 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (ch0_en_i),
    .gen_sel_i (ch0_gen_sel_i),
    .freq_i    (ch0_freq_i),
    .volume_i  (ch0_volume_i),
    .sample_o  (ch0_s)
  );

  audio_channel_osc #(
    .PHASE_W    (PHASE_W)
`ifdef AUDIO_NOISE_GEN_EN
    ,
    .NOISE_SEED (NOISE_SEED)
`endif
  ) u_ch1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (ch1_en_i),
    .gen_sel_i (ch1_gen_sel_i),
    .freq_i    (ch1_freq_i),
    .volume_i  (ch1_volume_i),
    .sample_o  (ch1_s)
  );

  // Halve the 9-bit sum so two full-scale channels cannot overflow, then
  // shift to offset-128
  always_comb begin
    sum_w    = 9'(ch0_s) + 9'(ch1_s);
    sample_d = 8'(sum_w >>> 1) + SAMPLE_MID;
  end

  // Stage B output register; reset parks the output at mid-scale silence
  always_ff @(posedge clk_i) begin
    if (rst_i) sample_q <= SAMPLE_MID;
    else       sample_q <= sample_d;
  end

  assign sample_data_o = sample_q;

endmodule

// File: tb/tb_audio_mixer_2ch.sv
// Scoreboard bench for audio_mixer_2ch: stimulus pushes expected samples
// from an arithmetic reference model; a monitor pops and compares them.
`timescale 1ns/1ps
module tb_audio_mixer_2ch;

  localparam int          PHASE_W    = 27;
  localparam int unsigned PHASE_MASK = (32'd1 << PHASE_W) - 32'd1;
  localparam int unsigned SEED       = 32'h0000ACE1;
  localparam real         PI         = 3.14159265358979323846;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ch0_en_i = 1'b0, ch1_en_i = 1'b0;
  logic [2:0]  ch0_gen_sel_i = '0, ch1_gen_sel_i = '0;
  logic [15:0] ch0_freq_i = '0, ch1_freq_i = '0;
  logic [7:0]  ch0_volume_i = '0, ch1_volume_i = '0;
  logic [7:0]  sample_data_o;

  always #40 clk_i = ~clk_i;

  audio_mixer_2ch dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ch0_en_i      (ch0_en_i),
    .ch0_gen_sel_i (ch0_gen_sel_i),
    .ch0_freq_i    (ch0_freq_i),
    .ch0_volume_i  (ch0_volume_i),
    .ch1_en_i      (ch1_en_i),
    .ch1_gen_sel_i (ch1_gen_sel_i),
    .ch1_freq_i    (ch1_freq_i),
    .ch1_volume_i  (ch1_volume_i),
    .sample_data_o (sample_data_o)
  );

  typedef struct {
    int unsigned cyc;
    int          val;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned edge_cnt = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  bit          cfg_rst = 1'b1;
  bit          cfg_en[2];
  int unsigned cfg_gen[2], cfg_freq[2], cfg_vol[2];
  int unsigned m_phase[2], m_lfsr[2];

  function automatic int floor_div(int a, int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int ref_wave(int unsigned g, int unsigned p, int unsigned lfsr);
    real r;
    int  b;
    b = int'(lfsr & 32'hFF);
    case (g)
      1: return (p < 128) ? 127 : -127;
      2: return int'(p) - 128;
      3: return 2 * ((p < 128) ? int'(p) : 255 - int'(p)) - 127;
      4: begin
        r = 127.0 * $sin(2.0 * PI * real'(p) / 256.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
      end
`ifdef AUDIO_NOISE_GEN_EN
      5: return (b >= 128) ? b - 256 : b;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned lfsr_next(int unsigned l);
    int unsigned fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 32'd1;
    return ((l << 1) | fb) & 32'hFFFF;
  endfunction

  function automatic int unsigned rand_freq();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return $urandom_range(1, 1023);
      default: return $urandom_range(1024, 65535);
    endcase
  endfunction

  task automatic set_ch(int c, bit en, int unsigned g, int unsigned f, int unsigned v);
    cfg_en[c] = en; cfg_gen[c] = g; cfg_freq[c] = f; cfg_vol[c] = v;
  endtask

  task automatic rand_ch(int c);
    int unsigned k;
    k = $urandom_range(0, 3);
    set_ch(c, $urandom_range(0, 4) != 0, $urandom_range(0, 7), rand_freq(),
           (k == 0) ? 0 : (k == 1) ? 255 : $urandom_range(1, 254));
  endtask

  // Drive one cycle of inputs and push the sample they produce two edges later
  task automatic step();
    int unsigned m, p_now, nxt;
    int          s[2];
    @(negedge clk_i);
    rst_i = cfg_rst;
    ch0_en_i = cfg_en[0]; ch0_gen_sel_i = 3'(cfg_gen[0]);
    ch0_freq_i = 16'(cfg_freq[0]); ch0_volume_i = 8'(cfg_vol[0]);
    ch1_en_i = cfg_en[1]; ch1_gen_sel_i = 3'(cfg_gen[1]);
    ch1_freq_i = 16'(cfg_freq[1]); ch1_volume_i = 8'(cfg_vol[1]);
    m = edge_cnt;
    if (cfg_rst) begin
      if (exp_q.size() > 0 && exp_q[$].cyc == m + 1) void'(exp_q.pop_back());
      exp_q.push_back('{m + 1, 128});
      exp_q.push_back('{m + 2, 128});
      for (int c = 0; c < 2; c++) begin
        m_phase[c] = 0;
        m_lfsr[c]  = SEED;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        p_now = m_phase[c] >> (PHASE_W - 8);
        s[c]  = cfg_en[c] ?
                floor_div(ref_wave(cfg_gen[c], p_now, m_lfsr[c]) * int'(cfg_vol[c]), 256) : 0;
        nxt = (m_phase[c] + cfg_freq[c]) & PHASE_MASK;
        if (cfg_en[c] && (nxt >> (PHASE_W - 8)) != p_now) m_lfsr[c] = lfsr_next(m_lfsr[c]);
        m_phase[c] = cfg_en[c] ? nxt : 0;
      end
      exp_q.push_back('{m + 2, floor_div(s[0] + s[1], 2) + 128});
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compare whenever the output for a scheduled edge is present
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
        e = exp_q.pop_front();
        n_checks++;
        $display("FAIL sample_skipped cyc=%0d expected %0d was never compared", e.cyc, e.val);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
        e = exp_q.pop_front();
        n_checks++;
        if (sample_data_o === 8'(e.val)) n_pass++;
        else $display("FAIL sample_data_o cyc=%0d got %0d expected %0d", edge_cnt, sample_data_o, e.val);
      end
    end
  end

  initial begin : watchdog
    #(90000 * 80);
    $display("FAIL watchdog: bench did not finish within cycle budget");
    $fatal(1);
  end

  initial begin : stimulus
    // reset held two cycles while both channels are enabled with random settings
    for (int c = 0; c < 2; c++) set_ch(c, 1'b1, $urandom_range(1, 4), rand_freq(), $urandom_range(1, 255));
    cfg_rst = 1'b1;
    run(2);
    cfg_rst = 1'b0;

    // ch1 square alone: 191 / 64 toggle after ~15948 cycles
    set_ch(0, 1'b0, 0, 0, 0);
    set_ch(1, 1'b1, 1, 4208, 255);
    run(16100);

    // sine + square, enable dropped then restored (phase restarts at 0)
    set_ch(0, 1'b1, 4, 4208, 255);
    set_ch(1, 1'b1, 1, 4208, 255);
    run(3000);
    cfg_en[0] = 1'b0; cfg_en[1] = 1'b0;
    run(6);
    cfg_en[0] = 1'b1; cfg_en[1] = 1'b1;
    run(3000);

    // frequency steps with enable held: phase stays continuous
    set_ch(0, 1'b1, 2, 4208, 255);
    set_ch(1, 1'b1, 3, 4208, 200);
    run(2000);
    cfg_freq[0] = 3339; cfg_freq[1] = 3339;
    run(2000);
    cfg_freq[0] = 5005; cfg_freq[1] = 5005;
    run(2000);

    // frozen phase and zero volume corner cases
    set_ch(1, 1'b0, 0, 0, 0);
    set_ch(0, 1'b1, 1, 0, 255);
    run(40);
    set_ch(0, 1'b1, 4, 0, 255);
    run(40);
    for (int g = 1; g < 8; g++) begin
      set_ch(0, 1'b1, g, 50000, 0);
      set_ch(1, 1'b1, g, 30000, 0);
      run(20);
    end

    // noise and reserved selects
    for (int g = 5; g < 8; g++) begin
      set_ch(0, 1'b1, g, 60000, 200);
      set_ch(1, 1'b1, g, 40000, 255);
      run(400);
    end

    // randomized segments with occasional mid-run reset, freq and enable changes
    repeat (60) begin
      int n;
      rand_ch(0);
      rand_ch(1);
      if ($urandom_range(0, 9) == 0) begin
        cfg_rst = 1'b1;
        run($urandom_range(1, 2));
        cfg_rst = 1'b0;
      end
      n = $urandom_range(20, 300);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 63) == 0) cfg_freq[$urandom_range(0, 1)] = rand_freq();
        if ($urandom_range(0, 127) == 0) begin
          int k;
          k = $urandom_range(0, 1);
          cfg_en[k] = ~cfg_en[k];
        end
        step();
      end
    end

    // both channels off: output returns to mid-scale
    cfg_en[0] = 1'b0; cfg_en[1] = 1'b0;
    run(4);
    repeat (3) @(posedge clk_i);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got %0d pending expected 0 pending", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
